// File: rtl/mc_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing for an 8-instruction subset.
// Outputs are combinational from the current state, the instruction fields and the handshakes.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic       ExtControl,
  output logic [2:0] ALUOp,
  output logic [2:0] state,
  output logic       illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_addu, w_subu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_legal;

  assign w_addu  = (op == 6'h00) && (funct == 6'h21);
  assign w_subu  = (op == 6'h00) && (funct == 6'h23);
  assign w_ori   = (op == 6'h0D);
  assign w_lui   = (op == 6'h0F);
  assign w_lw    = (op == 6'h23);
  assign w_sw    = (op == 6'h2B);
  assign w_beq   = (op == 6'h04);
  assign w_j     = (op == 6'h02);
  assign w_legal = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq | w_j;

  // State register; reset overrides every transition, including HALT and stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_j)           w_next = S_FETCH;
        else if (!w_legal) w_next = S_HALT;
        else               w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_beq)             w_next = S_FETCH;
        else if (w_lw || w_sw) w_next = S_MEM;
        else                   w_next = S_WB;
      end
      S_MEM: begin
        if (!mem_ready) w_next = S_MEM;
        else if (w_lw)  w_next = S_WB;
        else            w_next = S_FETCH;
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Output decode; reset masks every enable and forces the debug state to FETCH
  always_comb begin
    PCWrite    = 1'b0;
    PCSrc      = 2'd0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = ALU_ADD;
    illegal    = 1'b0;
    ExtControl = w_ori | w_lui;
    state      = reset ? S_FETCH : r_state;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          if (w_j) begin
            PCWrite = 1'b1;
            PCSrc   = 2'd2;
          end else begin
            PCWrite = 1'b0;
          end
        end
        S_EXEC: begin
          ALUSrc = w_ori | w_lui | w_lw | w_sw;
          if (w_subu || w_beq) ALUOp = ALU_SUB;
          else if (w_ori)      ALUOp = ALU_OR;
          else if (w_lui)      ALUOp = ALU_LUI;
          else                 ALUOp = ALU_ADD;
          if (w_beq) begin
            PCWrite = zero;
            PCSrc   = 2'd1;
          end else begin
            PCWrite = 1'b0;
          end
        end
        S_MEM: begin
          MemRead  = w_lw;
          MemWrite = w_sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = w_addu | w_subu;
          MemtoReg = w_lw;
        end
        S_HALT:  illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end else begin
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl: the driver queues hand-computed output vectors,
// a monitor pops and compares one vector every falling edge.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrc, ExtControl, illegal;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp, state;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
    .ExtControl(ExtControl), .ALUOp(ALUOp), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrc, ExtControl, ALUOp, illegal}
  localparam logic [17:0] X_ZERO  = {3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] F_WAIT  = {3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] F_GO    = {3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] F_GO_E  = {3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
  localparam logic [17:0] D_ZERO  = {3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] D_E     = {3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
  localparam logic [17:0] D_J     = {3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] E_ADDU  = {3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] E_SUBU  = {3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
  localparam logic [17:0] E_ORI   = {3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
  localparam logic [17:0] E_LUI   = {3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
  localparam logic [17:0] E_MEMOP = {3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] E_BEQ1  = {3'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
  localparam logic [17:0] E_BEQ0  = {3'd2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
  localparam logic [17:0] M_RD    = {3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] M_WR    = {3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] W_R     = {3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] W_I     = {3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
  localparam logic [17:0] W_LW    = {3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [17:0] H_ILL   = {3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

  localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02, OP_BAD = 6'h3F;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_NONE = 6'h00;

  logic [17:0] exp_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        done = 1'b0;

  // One clock of stimulus plus the vector the outputs must show during it
  task automatic cyc(input string nm, input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic [17:0] e);
    @(posedge clk);
    #1;
    reset = rst; op = o; funct = f; zero = z; mem_ready = mr;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: compares one queued vector per cycle, mid-cycle
  initial begin
    logic [17:0] act, e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        act = {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
               ALUSrc, ExtControl, ALUOp, illegal};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s got=%b exp=%b", nm, act, e);
        end
      end
      if (done && exp_q.size() == 0) begin
        if (checks < 12) begin
          errors++;
          $display("FAIL too few vectors compared: %0d", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1; op = OP_R; funct = F_ADDU; zero = 1'b0; mem_ready = 1'b0;
    cyc("reset0", 1'b1, OP_R, F_ADDU, 1'b0, 1'b0, X_ZERO);
    cyc("reset1", 1'b1, OP_R, F_ADDU, 1'b0, 1'b1, X_ZERO);
    // addu
    cyc("addu_f", 1'b0, OP_R, F_ADDU, 1'b0, 1'b1, F_GO);
    cyc("addu_d", 1'b0, OP_R, F_ADDU, 1'b0, 1'b1, D_ZERO);
    cyc("addu_e", 1'b0, OP_R, F_ADDU, 1'b0, 1'b1, E_ADDU);
    cyc("addu_w", 1'b0, OP_R, F_ADDU, 1'b0, 1'b1, W_R);
    // subu
    cyc("subu_f", 1'b0, OP_R, F_SUBU, 1'b0, 1'b1, F_GO);
    cyc("subu_d", 1'b0, OP_R, F_SUBU, 1'b0, 1'b1, D_ZERO);
    cyc("subu_e", 1'b0, OP_R, F_SUBU, 1'b0, 1'b1, E_SUBU);
    cyc("subu_w", 1'b0, OP_R, F_SUBU, 1'b0, 1'b1, W_R);
    // ori / lui: zero-extend everywhere
    cyc("ori_f", 1'b0, OP_ORI, F_NONE, 1'b0, 1'b1, F_GO_E);
    cyc("ori_d", 1'b0, OP_ORI, F_NONE, 1'b0, 1'b1, D_E);
    cyc("ori_e", 1'b0, OP_ORI, F_NONE, 1'b0, 1'b1, E_ORI);
    cyc("ori_w", 1'b0, OP_ORI, F_NONE, 1'b0, 1'b1, W_I);
    cyc("lui_f", 1'b0, OP_LUI, F_NONE, 1'b0, 1'b1, F_GO_E);
    cyc("lui_d", 1'b0, OP_LUI, F_NONE, 1'b0, 1'b1, D_E);
    cyc("lui_e", 1'b0, OP_LUI, F_NONE, 1'b0, 1'b1, E_LUI);
    cyc("lui_w", 1'b0, OP_LUI, F_NONE, 1'b0, 1'b1, W_I);
    // lw with three stall cycles in MEM: 8 cycles total
    cyc("lw_f", 1'b0, OP_LW, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("lw_d", 1'b0, OP_LW, F_NONE, 1'b0, 1'b0, D_ZERO);
    cyc("lw_e", 1'b0, OP_LW, F_NONE, 1'b0, 1'b0, E_MEMOP);
    for (int i = 0; i < 3; i++) cyc("lw_mstall", 1'b0, OP_LW, F_NONE, 1'b0, 1'b0, M_RD);
    cyc("lw_mdone", 1'b0, OP_LW, F_NONE, 1'b0, 1'b1, M_RD);
    cyc("lw_w", 1'b0, OP_LW, F_NONE, 1'b0, 1'b1, W_LW);
    // sw: no WB
    cyc("sw_f", 1'b0, OP_SW, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("sw_d", 1'b0, OP_SW, F_NONE, 1'b0, 1'b1, D_ZERO);
    cyc("sw_e", 1'b0, OP_SW, F_NONE, 1'b0, 1'b1, E_MEMOP);
    cyc("sw_m", 1'b0, OP_SW, F_NONE, 1'b0, 1'b1, M_WR);
    // beq taken / not taken
    cyc("beq1_f", 1'b0, OP_BEQ, F_NONE, 1'b1, 1'b1, F_GO);
    cyc("beq1_d", 1'b0, OP_BEQ, F_NONE, 1'b1, 1'b1, D_ZERO);
    cyc("beq1_e", 1'b0, OP_BEQ, F_NONE, 1'b1, 1'b1, E_BEQ1);
    cyc("beq0_f", 1'b0, OP_BEQ, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("beq0_d", 1'b0, OP_BEQ, F_NONE, 1'b0, 1'b1, D_ZERO);
    cyc("beq0_e", 1'b0, OP_BEQ, F_NONE, 1'b0, 1'b1, E_BEQ0);
    // j
    cyc("j_f", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("j_d", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, D_J);
    // fetch stall with reset in the middle
    cyc("fstall0", 1'b0, OP_J, F_NONE, 1'b0, 1'b0, F_WAIT);
    cyc("fstall1", 1'b0, OP_J, F_NONE, 1'b0, 1'b0, F_WAIT);
    cyc("fstall_rst0", 1'b1, OP_J, F_NONE, 1'b0, 1'b0, X_ZERO);
    cyc("fstall_rst1", 1'b1, OP_J, F_NONE, 1'b0, 1'b0, X_ZERO);
    cyc("fstall_rel", 1'b0, OP_J, F_NONE, 1'b0, 1'b0, F_WAIT);
    cyc("fstall_go", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("fstall_d", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, D_J);
    // illegal opcode: HALT for 10 cycles, then reset pulse
    cyc("bad_f", 1'b0, OP_BAD, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("bad_d", 1'b0, OP_BAD, F_NONE, 1'b0, 1'b1, D_ZERO);
    for (int i = 0; i < 10; i++) cyc("halt", 1'b0, OP_BAD, F_NONE, 1'b1, 1'b1, H_ILL);
    cyc("halt_rst", 1'b1, OP_BAD, F_NONE, 1'b0, 1'b1, X_ZERO);
    cyc("halt_rel_f", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("halt_rel_d", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, D_J);
    // illegal funct under op 0
    cyc("badf_f", 1'b0, OP_R, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("badf_d", 1'b0, OP_R, F_NONE, 1'b0, 1'b1, D_ZERO);
    cyc("badf_h", 1'b0, OP_R, F_NONE, 1'b0, 1'b1, H_ILL);
    cyc("badf_rst", 1'b1, OP_R, F_NONE, 1'b0, 1'b1, X_ZERO);
    // reset during a MEM stall
    cyc("mrst_f", 1'b0, OP_LW, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("mrst_d", 1'b0, OP_LW, F_NONE, 1'b0, 1'b1, D_ZERO);
    cyc("mrst_e", 1'b0, OP_LW, F_NONE, 1'b0, 1'b1, E_MEMOP);
    cyc("mrst_m", 1'b0, OP_LW, F_NONE, 1'b0, 1'b0, M_RD);
    cyc("mrst_rst", 1'b1, OP_LW, F_NONE, 1'b0, 1'b0, X_ZERO);
    cyc("mrst_f2", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, F_GO);
    cyc("mrst_d2", 1'b0, OP_J, F_NONE, 1'b0, 1'b1, D_J);
    done = 1'b1;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 op  in  6  opcode field of the instruction register (IR[31:26]).
REQ-005 funct  in  6  function field of the instruction register (IR[5:0]).
REQ-006 zero  in  1  ALU zero flag, valid in EXEC.
REQ-007 mem_ready  in  1  memory completion handshake; access completes in any cycle it is 1 while a request is asserted.
REQ-008 PCWrite  out  1  PC load enable.
REQ-009 PCSrc  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-010 IRWrite  out  1  instruction register load enable.
REQ-011 MemRead / MemWrite  out  1 each  memory request strobes.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 RegDst  out  1  1 = rd, 0 = rt.  MemtoReg  out  1  1 = memory data, 0 = ALU result.
REQ-014 ALUSrc  out  1  1 = extended immediate, 0 = rt.
REQ-015 ExtControl  out  1  drives the immediate extender: 1 = zero-extend, 0 = sign-extend.
REQ-016 ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
REQ-017 state  out  3  current state code (debug).  illegal  out  1  high while in HALT.

Function
REQ-018 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH next cycle.
REQ-019 Supported: addu (op 0, funct 0x21), subu (op 0, funct 0x23), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02; anything else is illegal.
REQ-020 Outputs SHALL be combinational from state, op, funct, zero, mem_ready; every enable/strobe not listed for a state SHALL be 0.
REQ-021 FETCH: MemRead=1; while mem_ready=0 stay in FETCH; when mem_ready=1 assert IRWrite=1, PCWrite=1, PCSrc=0 in that same cycle and go to DECODE.
REQ-022 DECODE: j -> PCWrite=1, PCSrc=2, next FETCH; illegal -> next HALT; otherwise next EXEC.
REQ-023 EXEC: ALUSrc=1 for ori/lui/lw/sw, 0 for addu/subu/beq; ALUOp per instruction (lw/sw add, beq sub).
REQ-024 EXEC beq: PCWrite=zero, PCSrc=1, next FETCH; lw/sw next MEM; addu/subu/ori/lui next WB.
REQ-025 ExtControl SHALL be 1 for ori and lui, 0 for all other instructions, in every state.
REQ-026 MEM lw: MemRead=1 until mem_ready=1, then next WB; sw: MemWrite=1 until mem_ready=1, then next FETCH; stall indefinitely while mem_ready=0.
REQ-027 WB: RegWrite=1; RegDst=1 only for addu/subu; MemtoReg=1 only for lw; next FETCH.
REQ-028 HALT: illegal=1, all enables 0, remain until reset.
REQ-029 Latency with mem_ready tied 1: j 2 cycles, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.
REQ-030 op/funct SHALL be considered stable from DECODE to end of instruction; mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-031 reset=1 on a rising edge SHALL force state to FETCH regardless of current state (including mid-MEM stall and HALT), overriding all transitions.
REQ-032 While reset=1 all write enables and strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) SHALL be 0, illegal=0, state=0.

Verification
REQ-033 addu, mem_ready=1: states 0,1,2,4,0; RegWrite=1 only in WB with RegDst=1, ALUOp=000, ExtControl=0.
REQ-034 lw with mem_ready=0 for 3 cycles in MEM: MemRead held 4 cycles, then WB with MemtoReg=1; total 8 cycles.
REQ-035 beq zero=1 -> PCWrite=1, PCSrc=1 in EXEC; zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-036 ori and lui: ExtControl=1, ALUSrc=1, ALUOp 010/011, RegDst=0; sw: ExtControl=0, MemWrite=1 in MEM, no WB.
REQ-037 op=0x3F: DECODE -> HALT, illegal=1 held 10 cycles; reset pulse -> state=0, illegal=0 next cycle.
REQ-038 reset asserted during FETCH stall (mem_ready=0): state stays 0, MemRead=0 while reset=1, resumes fetch after release.
